// File: rtl/data_mem_arbiter.sv
// Core/DMA data-memory arbiter: fixed priority with DMA starvation guard, or round robin when DMEM_ARB_ROUND_ROBIN_EN is defined.
// Grant is combinational and read data returns one cycle after it; a losing requester sees core_stall=1 / dma_gnt=0 and holds.
module data_mem_arbiter #(
  parameter int DMA_MAX_WAIT = 8,
  parameter int WAIT_CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_memread,
  input  logic        core_memwrite,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_sign_mask,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_DMA} rd_owner_e;
  typedef enum logic {LG_CORE, LG_DMA} last_grant_e;

  localparam logic [WAIT_CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(DMA_MAX_WAIT);

  logic                  w_core_req;
  logic                  w_dma_win;
  logic                  w_core_win;
  rd_owner_e             r_rd_owner;
  rd_owner_e             w_rd_owner_nxt;
  last_grant_e           r_last_grant;
  last_grant_e           w_last_grant_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;

  assign w_core_req = core_memread | core_memwrite;

  // Grants are forced off while reset is asserted so no access escapes to memory.
  always_comb begin
    w_dma_win  = 1'b0;
    w_core_win = 1'b0;
    if (rst_n) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      w_dma_win  = dma_req & (~w_core_req | (r_last_grant == LG_CORE));
`else
      w_dma_win  = dma_req & (~w_core_req | (r_wait_cnt >= WAIT_LIMIT));
`endif
      w_core_win = w_core_req & ~w_dma_win;
    end
  end

  always_comb begin
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_memread   = 1'b0;
    mem_memwrite  = 1'b0;
    mem_sign_mask = '0;
    if (w_dma_win) begin
      mem_addr      = dma_addr;
      mem_wdata     = dma_wdata;
      mem_memread   = ~dma_we;
      mem_memwrite  = dma_we;
      mem_sign_mask = 4'b0111;
    end else if (w_core_win) begin
      mem_addr      = core_addr;
      mem_wdata     = core_wdata;
      mem_memread   = core_memread;
      mem_memwrite  = core_memwrite;
      mem_sign_mask = core_sign_mask;
    end
  end

  assign dma_gnt    = w_dma_win;
  assign core_stall = rst_n & w_core_req & ~w_core_win;
  assign core_rdata = mem_read_data;
  assign dma_rvalid = (r_rd_owner == RD_DMA);
  assign dma_rdata  = dma_rvalid ? mem_read_data : '0;

  always_comb begin
    w_rd_owner_nxt   = RD_NONE;
    w_last_grant_nxt = r_last_grant;
    if (w_dma_win) begin
      w_last_grant_nxt = LG_DMA;
      if (!dma_we) w_rd_owner_nxt = RD_DMA;
    end else if (w_core_win) begin
      w_last_grant_nxt = LG_CORE;
      if (core_memread) w_rd_owner_nxt = RD_CORE;
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  assign w_wait_cnt_nxt = '0;
`else
  always_comb begin
    w_wait_cnt_nxt = r_wait_cnt;
    if (!dma_req || w_dma_win) begin
      w_wait_cnt_nxt = '0;
    end else if (r_wait_cnt != CNT_MAX) begin
      w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner   <= RD_NONE;
      r_last_grant <= LG_DMA;
      r_wait_cnt   <= '0;
    end else begin
      r_rd_owner   <= w_rd_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_data_mem_arbiter;
  localparam int MAXW = 8;
  localparam int CW   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_memread, core_memwrite;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_sign_mask;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_memread, mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_arbiter #(.DMA_MAX_WAIT(MAXW), .WAIT_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_memread(core_memread), .core_memwrite(core_memwrite),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_sign_mask(core_sign_mask),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Environment memory: unwritten words read back a fixed pattern derived from their index.
  logic [31:0] env_mem [0:255];
  bit          env_vld [0:255];

  function automatic logic [31:0] init_word(input int idx);
    return 32'hA000_0000 | 32'(idx);
  endfunction

  always @(posedge clk) begin
    if (mem_memwrite) begin
      env_mem[mem_addr[9:2]] <= mem_wdata;
      env_vld[mem_addr[9:2]] <= 1'b1;
    end
    if (mem_memread)
      mem_read_data <= env_vld[mem_addr[9:2]] ? env_mem[mem_addr[9:2]] : init_word(int'(mem_addr[9:2]));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #4;
  endtask

  task automatic idle_inputs;
    core_memread = 1'b0; core_memwrite = 1'b0; core_addr = '0; core_wdata = '0; core_sign_mask = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    core_memread = 1'b1; core_addr = 32'h1004;
    dma_req = 1'b1; dma_addr = 32'h1008;
    tick(); settle();
    n_tests++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_dma_gnt got=%b exp=0", dma_gnt); end
    n_tests++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_dma_rvalid got=%b exp=0", dma_rvalid); end
    n_tests++; if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rw got=%b%b exp=00", mem_memread, mem_memwrite); end
    n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rst_core_stall got=%b exp=0", core_stall); end
    n_tests++; if (dma_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_dma_rdata got=%h exp=0", dma_rdata); end
    tick();
    rst_n = 1'b1;
    settle();
    n_tests++; if (core_stall !== 1'b0 || dma_gnt !== 1'b0) begin n_fail++; $display("FAIL first_contend stall=%b gnt=%b exp=0,0", core_stall, dma_gnt); end
    n_tests++; if (mem_memread !== 1'b1 || mem_addr !== 32'h1004) begin n_fail++; $display("FAIL first_contend_mem rd=%b addr=%h exp=1,00001004", mem_memread, mem_addr); end
  endtask

  task automatic test_rd_collision;
    apply_reset();
    core_memread = 1'b1; core_addr = 32'h1004; core_sign_mask = 4'b0010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h1008;
    settle();
    n_tests++; if (core_stall !== 1'b0 || dma_gnt !== 1'b0) begin n_fail++; $display("FAIL coll_c0 stall=%b gnt=%b exp=0,0", core_stall, dma_gnt); end
    n_tests++; if (mem_addr !== 32'h1004 || mem_sign_mask !== 4'b0010) begin n_fail++; $display("FAIL coll_c0_mem addr=%h mask=%b exp=00001004,0010", mem_addr, mem_sign_mask); end
    tick();
    core_memread = 1'b0;
    settle();
    n_tests++; if (core_rdata !== 32'hA000_0001) begin n_fail++; $display("FAIL coll_c1_core_rdata got=%h exp=a0000001", core_rdata); end
    n_tests++; if (dma_gnt !== 1'b1 || mem_addr !== 32'h1008 || mem_sign_mask !== 4'b0111) begin n_fail++; $display("FAIL coll_c1_dma gnt=%b addr=%h mask=%b exp=1,00001008,0111", dma_gnt, mem_addr, mem_sign_mask); end
    tick();
    dma_req = 1'b0;
    settle();
    n_tests++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hA000_0002) begin n_fail++; $display("FAIL coll_c2_dma rvalid=%b rdata=%h exp=1,a0000002", dma_rvalid, dma_rdata); end
    tick();
    settle();
    n_tests++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL coll_c3_rvalid got=%b exp=0", dma_rvalid); end
  endtask

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin;
    apply_reset();
    core_memread = 1'b1; core_addr = 32'h1004;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h1008;
    for (int c = 0; c < 8; c++) begin
      settle();
      n_tests++; if (dma_gnt !== c[0] || core_stall !== c[0]) begin n_fail++; $display("FAIL rr_cycle%0d gnt=%b stall=%b exp=%b,%b", c, dma_gnt, core_stall, c[0], c[0]); end
      tick();
    end
    idle_inputs();
  endtask
`else
  task automatic test_starvation;
    logic exp_g;
    apply_reset();
    core_memread = 1'b1; core_addr = 32'h1004;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h1008;
    for (int c = 1; c <= 12; c++) begin
      exp_g = (c == MAXW + 1);
      settle();
      n_tests++; if (dma_gnt !== exp_g || core_stall !== exp_g) begin n_fail++; $display("FAIL starve_cycle%0d gnt=%b stall=%b exp=%b,%b", c, dma_gnt, core_stall, exp_g, exp_g); end
      tick();
    end
    idle_inputs();
  endtask
`endif

  task automatic test_write_read;
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h1010; dma_wdata = 32'hDEAD_BEEF;
    settle();
    n_tests++; if (dma_gnt !== 1'b1 || mem_memwrite !== 1'b1 || mem_memread !== 1'b0) begin n_fail++; $display("FAIL dmawr_gnt gnt=%b wr=%b rd=%b exp=1,1,0", dma_gnt, mem_memwrite, mem_memread); end
    n_tests++; if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h1010 || mem_sign_mask !== 4'b0111) begin n_fail++; $display("FAIL dmawr_mem wdata=%h addr=%h mask=%b exp=deadbeef,00001010,0111", mem_wdata, mem_addr, mem_sign_mask); end
    tick();
    dma_req = 1'b0; dma_we = 1'b0;
    core_memread = 1'b1; core_addr = 32'h1010; core_sign_mask = 4'b0010;
    settle();
    n_tests++; if (core_stall !== 1'b0 || mem_memread !== 1'b1 || mem_sign_mask !== 4'b0010) begin n_fail++; $display("FAIL corerd_gnt stall=%b rd=%b mask=%b exp=0,1,0010", core_stall, mem_memread, mem_sign_mask); end
    tick();
    core_memread = 1'b0;
    settle();
    n_tests++; if (core_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL corerd_data got=%h exp=deadbeef", core_rdata); end
    n_tests++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL corerd_no_dma_rvalid got=%b exp=0", dma_rvalid); end
    tick();
  endtask

  task automatic test_reset_mid_read;
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h1008;
    settle();
    n_tests++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt got=%b exp=1", dma_gnt); end
    tick();
    rst_n = 1'b0;
    core_memread = 1'b1; core_addr = 32'h1004;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_tests++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rvalid%0d rvalid=%b rdata=%h exp=0,0", c, dma_rvalid, dma_rdata); end
      n_tests++; if (dma_gnt !== 1'b0 || mem_memread !== 1'b0 || mem_memwrite !== 1'b0 || core_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_outs%0d gnt=%b rd=%b wr=%b stall=%b exp=0", c, dma_gnt, mem_memread, mem_memwrite, core_stall); end
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    settle();
    n_tests++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_release_rvalid got=%b exp=0", dma_rvalid); end
    tick();
  endtask

  task automatic test_drop_while_stalled;
    int k;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    k = 2;
`else
    k = MAXW + 1;
`endif
    apply_reset();
    core_memwrite = 1'b1; core_addr = 32'h1020; core_wdata = 32'h1111_2222; core_sign_mask = 4'b0010;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h1024; dma_wdata = 32'h3333_4444;
    for (int c = 1; c < k; c++) tick();
    core_memwrite = 1'b0; core_memread = 1'b1; core_addr = 32'h1004;
    settle();
    n_tests++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL drop_stalled got=%b exp=1", core_stall); end
    n_tests++; if (mem_memread !== 1'b0 || mem_memwrite !== 1'b1) begin n_fail++; $display("FAIL drop_stalled_mem rd=%b wr=%b exp=0,1", mem_memread, mem_memwrite); end
    tick();
    core_memread = 1'b0;
    dma_req = 1'b0;
    settle();
    n_tests++; if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0 || core_stall !== 1'b0) begin n_fail++; $display("FAIL drop_after rd=%b wr=%b stall=%b exp=0,0,0", mem_memread, mem_memwrite, core_stall); end
    n_tests++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL drop_after_rvalid got=%b exp=0", dma_rvalid); end
    tick();
    settle();
    n_tests++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL drop_after2_rvalid got=%b exp=0", dma_rvalid); end
    tick();
  endtask

  task automatic test_random;
    logic [31:0] rm [0:7];
    int          m_wait, m_rd;
    bit          m_last_dma, prev_cstall, prev_dpend;
    bit          creq, e_dma, e_core;
    logic [31:0] m_exp, e_addr;
    int          slot;
    for (int i = 0; i < 8; i++) rm[i] = init_word(64 + i);
    apply_reset();
    m_wait = 0; m_rd = 0; m_last_dma = 1'b1; m_exp = '0;
    prev_cstall = 1'b0; prev_dpend = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!(prev_cstall && $urandom_range(0, 99) < 85)) begin
        core_memread = 1'b0; core_memwrite = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1) core_memread = 1'b1; else core_memwrite = 1'b1;
          core_addr      = 32'h1100 + 32'(4 * $urandom_range(0, 7));
          core_wdata     = $urandom;
          core_sign_mask = 4'($urandom_range(0, 15));
        end
      end
      if (!(prev_dpend && $urandom_range(0, 99) < 85)) begin
        dma_req   = ($urandom_range(0, 99) < 60);
        dma_we    = 1'($urandom_range(0, 1));
        dma_addr  = 32'h1100 + 32'(4 * $urandom_range(0, 7));
        dma_wdata = $urandom;
      end
      creq = core_memread || core_memwrite;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      e_dma = dma_req && (!creq || !m_last_dma);
`else
      e_dma = dma_req && (!creq || m_wait >= MAXW);
`endif
      e_core = creq && !e_dma;
      e_addr = e_dma ? dma_addr : (e_core ? core_addr : 32'h0);
      settle();
      n_tests++; if (dma_gnt !== e_dma || core_stall !== (creq && !e_core)) begin n_fail++; $display("FAIL rnd%0d_grant gnt=%b stall=%b exp=%b,%b", cyc, dma_gnt, core_stall, e_dma, creq && !e_core); end
      n_tests++; if (mem_memread !== ((e_dma && !dma_we) || (e_core && core_memread)) || mem_memwrite !== ((e_dma && dma_we) || (e_core && core_memwrite)) || mem_addr !== e_addr) begin
        n_fail++; $display("FAIL rnd%0d_mem rd=%b wr=%b addr=%h exp_addr=%h", cyc, mem_memread, mem_memwrite, mem_addr, e_addr);
      end
      if (m_rd == 1) begin
        n_tests++; if (core_rdata !== m_exp || dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_core_rdata got=%h rvalid=%b exp=%h,0", cyc, core_rdata, dma_rvalid, m_exp); end
      end else if (m_rd == 2) begin
        n_tests++; if (dma_rvalid !== 1'b1 || dma_rdata !== m_exp) begin n_fail++; $display("FAIL rnd%0d_dma_rdata rvalid=%b got=%h exp=1,%h", cyc, dma_rvalid, dma_rdata, m_exp); end
      end else begin
        n_tests++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_idle_rvalid got=%b exp=0", cyc, dma_rvalid); end
      end
      m_rd = 0;
      slot = int'(e_addr[4:2]);
      if (e_dma) begin
        if (dma_we) rm[slot] = dma_wdata; else begin m_rd = 2; m_exp = rm[slot]; end
        m_last_dma = 1'b1;
      end else if (e_core) begin
        if (core_memwrite) rm[slot] = core_wdata; else begin m_rd = 1; m_exp = rm[slot]; end
        m_last_dma = 1'b0;
      end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      m_wait = 0;
`else
      if (dma_req && !e_dma) m_wait = (m_wait < (1 << CW) - 1) ? m_wait + 1 : m_wait;
      else m_wait = 0;
`endif
      prev_cstall = creq && !e_core;
      prev_dpend  = dma_req && !e_dma;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_rd_collision();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_starvation();
`endif
    test_write_read();
    test_reset_mid_read();
    test_drop_while_stalled();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DMA_MAX_WAIT, default 8: the number of consecutive cycles DMA may wait before it is force-granted in fixed-priority mode.
REQ-002 The block SHALL have parameter WAIT_CNT_W, default 4: the width of the DMA wait counter; DMA_MAX_WAIT SHALL be at most 2^WAIT_CNT_W-1.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 core_memread / core_memwrite  in  1 each  core load/store request; they are mutually exclusive.
REQ-006 core_addr / core_wdata  in  32 each; core_sign_mask  in  4: load/store type, passed through to memory.
REQ-007 core_rdata  out  32; core_stall  out  1: the core SHALL hold its request while core_stall=1.
REQ-008 dma_req  in  1; dma_we  in  1; dma_addr / dma_wdata  in  32 each: DMA/debug port, word accesses only.
REQ-009 dma_gnt  out  1; dma_rvalid  out  1; dma_rdata  out  32.
REQ-010 mem_addr / mem_wdata  out  32 each; mem_memread / mem_memwrite  out  1 each; mem_sign_mask  out  4; mem_read_data  in  32: single-port data memory with 1-cycle registered read.

Function
REQ-011 The arbiter SHALL select at most one owner per cycle, combinationally from the current requests and registered state, and SHALL drive the mem_* signals from that owner; with no owner, mem_memread = mem_memwrite = 0.
REQ-012 A DMA grant SHALL drive mem_sign_mask=4'b0111 (word), mem_memread=~dma_we, and mem_memwrite=dma_we.
REQ-013 core_stall SHALL be (core_memread|core_memwrite) & ~core_granted, combinationally.
REQ-014 dma_gnt SHALL be high in the cycle DMA owns memory; a DMA request is complete on dma_req&dma_gnt.
REQ-015 The block SHALL keep registered rd_owner in {NONE, CORE, DMA}; rd_owner SHALL be set to the owner of a granted read and to NONE otherwise.
REQ-016 When rd_owner=DMA, dma_rvalid SHALL be 1 and dma_rdata = mem_read_data, one cycle after the grant; dma_rvalid SHALL be 0 otherwise.
REQ-017 core_rdata SHALL equal mem_read_data at all times; the core samples it one cycle after its grant.
REQ-018 The block SHALL keep registered last_grant in {CORE, DMA}, updated on every grant.
REQ-019 The block SHALL keep a wait counter: +1 each cycle dma_req is high and not granted, saturating at 2^WAIT_CNT_W-1; cleared on any DMA grant or when dma_req=0.
REQ-020 Fixed-priority mode: core wins on contention; DMA SHALL win when core is idle, or when wait counter >= DMA_MAX_WAIT, for exactly one grant after which the counter clears.
REQ-021 A requester that drops its request while stalled SHALL receive no grant, and no memory access SHALL be issued for it.
REQ-022 Back-to-back grants to alternating owners SHALL have no idle bubble; a write followed by a read to the same address SHALL return the written data.

Reset
REQ-023 While rst_n=0, rd_owner SHALL be NONE, last_grant SHALL be DMA, and the wait counter SHALL be 0.
REQ-024 While rst_n=0, dma_gnt, dma_rvalid, mem_memread, mem_memwrite, and core_stall SHALL be 0, and dma_rdata SHALL be 0.
REQ-025 Reset asserted mid-read SHALL discard the pending dma_rvalid.
REQ-026 After deassertion of rst_n, the first contended cycle SHALL grant core.

Configuration
REQ-027 Macro DMEM_ARB_ROUND_ROBIN_EN, when defined: on contention the grant SHALL go to the requester not equal to last_grant; the wait counter is unused and held at 0.
REQ-028 Without DMEM_ARB_ROUND_ROBIN_EN, fixed-priority behaviour with the starvation guard (REQ-020) SHALL apply.

Verification
REQ-029 Core read of 0x1004 and simultaneous DMA read of 0x1008 (fixed priority): cycle 0 core granted and dma_gnt=0; cycle 1 core_rdata holds word 0x1004 and DMA granted; cycle 2 dma_rvalid=1 with word 0x1008.
REQ-030 Core requests every cycle and dma_req held (fixed priority, DMA_MAX_WAIT=8): dma_gnt=1 on the 9th cycle for one cycle; core_stall=1 in that cycle only.
REQ-031 DMA write 0xDEADBEEF to 0x1010, then core lw 0x1010: core_rdata=0xDEADBEEF one cycle after the core grant.
REQ-032 Continuous contention with DMEM_ARB_ROUND_ROBIN_EN: grants alternate core, DMA, core, DMA..., starting with core after reset.
REQ-033 rst_n pulled low the cycle after a DMA read grant: dma_rvalid stays 0 and all outputs are 0 until release.
REQ-034 Core asserts memread, then deasserts it while stalled: no mem_memread issued for the core and rd_owner stays NONE.
